// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: two-master round-robin Wishbone classic arbiter in front of a single slave port.
// Optional cycle watchdog compiled in with `define WB_ARB_WATCHDOG_EN.
module wb_rr_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk,
  input  logic            sys_rst_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  output logic [1:0]      gnt_o
);
  // State encoding doubles as the one-hot grant, so gnt_o comes straight from the state flops.
  typedef enum logic [1:0] {IDLE = 2'b00, GNT0 = 2'b01, GNT1 = 2'b10} state_t;
  state_t state, state_nx;
  logic last, to, g0, g1;
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("TIMEOUT out of range");
  end
  assign g0 = state == GNT0;
  assign g1 = state == GNT1;
  assign gnt_o = state;
  always_comb begin
    state_nx = IDLE;
    if (state == IDLE)
      state_nx = (m0_cyc_i && m1_cyc_i) ? (last ? GNT0 : GNT1) :
                 m0_cyc_i ? GNT0 : m1_cyc_i ? GNT1 : IDLE;
    else if (g0)
      state_nx = (m0_cyc_i && !to) ? GNT0 : IDLE;
    else if (g1)
      state_nx = (m1_cyc_i && !to) ? GNT1 : IDLE;
  end
  always_ff @(posedge wb_clk or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state <= IDLE;
      last <= 1'b1;
    end else begin
      state <= state_nx;
      if (state != IDLE && state_nx == IDLE) last <= g1;
    end
  end
`ifdef WB_ARB_WATCHDOG_EN
  logic [15:0] cnt;
  assign to = (state != IDLE) && (cnt == 16'(TIMEOUT));
  always_ff @(posedge wb_clk or posedge sys_rst_i) begin
    if (sys_rst_i) cnt <= '0;
    else cnt <= (state == IDLE || state_nx == IDLE || s_ack_i || s_err_i) ? '0 :
                s_stb_o ? cnt + 16'd1 : cnt;
  end
`else
  assign to = 1'b0;
`endif
  // A watchdog timeout withdraws the cycle from the slave in the same cycle the error is returned.
  always_comb begin
    s_cyc_o = g0 ? m0_cyc_i & ~to : g1 ? m1_cyc_i & ~to : 1'b0;
    s_stb_o = g0 ? m0_stb_i & ~to : g1 ? m1_stb_i & ~to : 1'b0;
    s_we_o  = g0 ? m0_we_i : g1 ? m1_we_i : 1'b0;
    s_adr_o = g0 ? m0_adr_i : g1 ? m1_adr_i : '0;
    s_dat_o = g0 ? m0_dat_i : g1 ? m1_dat_i : '0;
    s_sel_o = g0 ? m0_sel_i : g1 ? m1_sel_i : '0;
    m0_ack_o = g0 & s_ack_i;
    m1_ack_o = g1 & s_ack_i;
    m0_err_o = g0 & (s_err_i | to);
    m1_err_o = g1 & (s_err_i | to);
    m0_dat_o = g0 ? s_dat_i : '0;
    m1_dat_o = g1 ? s_dat_i : '0;
  end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: directed scenarios plus randomized traffic checked against an owner/last reference model.
module tb_wb_rr_arbiter;
  localparam int AW = 32, DW = 32, TO = 8;
`ifdef WB_ARB_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [AW-1:0] m0_adr, m1_adr, s_adr;
  logic [DW-1:0] m0_dat, m1_dat, m0_rdat, m1_rdat, s_wdat, s_rdat;
  logic [DW/8-1:0] m0_sel, m1_sel, s_sel;
  logic m0_ack, m0_err, m1_ack, m1_err;
  logic s_cyc, s_stb, s_we, s_ack, s_err;
  logic [1:0] gnt;
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  wb_rr_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .wb_clk(clk), .sys_rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr), .s_dat_o(s_wdat),
    .s_sel_o(s_sel), .s_dat_i(s_rdat), .s_ack_i(s_ack), .s_err_i(s_err), .gnt_o(gnt)
  );

  // Inputs change 1 time unit after the rising edge; outputs are checked 4 units later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, s_ack, s_err} = '0;
    {m0_adr, m1_adr, m0_dat, m1_dat, m0_sel, m1_sel, s_rdat} = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    s_ack = 1'b1;
    s_rdat = 32'hA5A5_5A5A;
    #4;
    n_checks++;
    if (gnt !== 2'b00 || s_cyc !== 1'b0 || s_stb !== 1'b0 || s_adr !== '0) begin
      n_fail++; $display("FAIL reset_outputs: gnt=%b s_cyc=%b s_stb=%b s_adr=%h, required 00 0 0 0", gnt, s_cyc, s_stb, s_adr);
    end
    n_checks++;
    if ({m0_ack, m1_ack, m0_err, m1_err} !== 4'b0 || m0_rdat !== '0 || m1_rdat !== '0) begin
      n_fail++; $display("FAIL reset_responses: acks/errs=%b m0_dat=%h m1_dat=%h, required 0", {m0_ack, m1_ack, m0_err, m1_err}, m0_rdat, m1_rdat);
    end
    s_ack = 1'b0;
    s_rdat = '0;
  endtask

  task automatic test_tie();
    do_reset();
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    step(); #4;
    n_checks++;
    if (gnt !== 2'b01) begin n_fail++; $display("FAIL tie_first: gnt=%b required 01", gnt); end
    m0_cyc = 1'b0;
    step(); #4;
    n_checks++;
    if (gnt !== 2'b00) begin n_fail++; $display("FAIL tie_gap: gnt=%b required 00", gnt); end
    step(); #4;
    n_checks++;
    if (gnt !== 2'b10) begin n_fail++; $display("FAIL tie_second: gnt=%b required 10", gnt); end
    m1_cyc = 1'b0;
  endtask

  task automatic test_m1_write();
    do_reset();
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1;
    m1_adr = 32'h0000_1000; m1_dat = 32'hDEAD_BEEF; m1_sel = 4'hF;
    m0_adr = 32'h1111_2222; m0_dat = 32'h3333_4444; m0_sel = 4'h3;
    #4;
    n_checks++;
    if (s_cyc !== 1'b0) begin n_fail++; $display("FAIL write_pre_grant: s_cyc=%b required 0", s_cyc); end
    step();
    s_ack = 1'b1;
    #4;
    n_checks++;
    if ({s_cyc, s_stb, s_we} !== 3'b111 || s_adr !== 32'h1000 || s_wdat !== 32'hDEAD_BEEF || s_sel !== 4'hF) begin
      n_fail++; $display("FAIL write_mux: cyc/stb/we=%b adr=%h dat=%h sel=%h required 111 1000 deadbeef f", {s_cyc, s_stb, s_we}, s_adr, s_wdat, s_sel);
    end
    n_checks++;
    if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin
      n_fail++; $display("FAIL write_ack: m1_ack=%b m0_ack=%b required 1 0", m1_ack, m0_ack);
    end
    step();
    s_ack = 1'b0; m1_stb = 1'b0;
    #4;
    n_checks++;
    if (m1_ack !== 1'b0) begin n_fail++; $display("FAIL write_ack_low: m1_ack=%b required 0", m1_ack); end
    m1_cyc = 1'b0; m1_we = 1'b0;
  endtask

  task automatic test_block();
    int acks = 0;
    do_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      s_ack = 1'b1;
      s_rdat = 32'(k);
      #4;
      if (m0_ack === 1'b1) acks++;
      n_checks++;
      if (gnt !== 2'b01 || m0_rdat !== 32'(k) || m1_ack !== 1'b0) begin
        n_fail++; $display("FAIL block_beat%0d: gnt=%b m0_dat=%h m1_ack=%b required 01 %h 0", k, gnt, m0_rdat, m1_ack, k);
      end
    end
    step();
    s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    #4;
    n_checks++;
    if (acks != 4 || gnt !== 2'b01) begin
      n_fail++; $display("FAIL block_acks: acks=%0d gnt=%b required 4 01", acks, gnt);
    end
    step(); #4;
    n_checks++;
    if (gnt !== 2'b00) begin n_fail++; $display("FAIL block_gap: gnt=%b required 00", gnt); end
    step(); #4;
    n_checks++;
    if (gnt !== 2'b10) begin n_fail++; $display("FAIL block_handover: gnt=%b required 10", gnt); end
    m1_cyc = 1'b0; m1_stb = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_g;
    do_reset();
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      step();
      if (exp_g[0]) m0_cyc = 1'b0; else m1_cyc = 1'b0;
      #4;
      n_checks++;
      if (gnt !== exp_g) begin n_fail++; $display("FAIL alt_grant%0d: gnt=%b required %b", i, gnt, exp_g); end
      step();
      m0_cyc = 1'b1; m1_cyc = 1'b1;
      #4;
      n_checks++;
      if (gnt !== 2'b00) begin n_fail++; $display("FAIL alt_gap%0d: gnt=%b required 00", i, gnt); end
    end
    m0_cyc = 1'b0; m1_cyc = 1'b0;
  endtask

  task automatic test_watchdog();
    int first_err = -1;
    do_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step(); #4;
      if (m0_err === 1'b1 && first_err < 0) first_err = k;
      if (WD && k == TO + 1) begin
        n_checks++;
        if (m0_err !== 1'b1 || s_cyc !== 1'b0 || s_stb !== 1'b0) begin
          n_fail++; $display("FAIL wd_pulse: m0_err=%b s_cyc=%b s_stb=%b required 1 0 0", m0_err, s_cyc, s_stb);
        end
      end
      if (WD && k == TO + 2) begin
        n_checks++;
        if (gnt !== 2'b00 || m0_err !== 1'b0) begin
          n_fail++; $display("FAIL wd_idle: gnt=%b m0_err=%b required 00 0", gnt, m0_err);
        end
      end
      if (!WD) begin
        n_checks++;
        if (gnt !== 2'b01 || m0_err !== 1'b0) begin
          n_fail++; $display("FAIL wd_off_hold%0d: gnt=%b m0_err=%b required 01 0", k, gnt, m0_err);
        end
      end
    end
    n_checks++;
    if (first_err != (WD ? TO + 1 : -1)) begin
      n_fail++; $display("FAIL wd_first_err: cycle=%0d required %0d", first_err, WD ? TO + 1 : -1);
    end
    m0_cyc = 1'b0; m0_stb = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    m1_cyc = 1'b1; m1_stb = 1'b1;
    step(); step();
    s_ack = 1'b1;
    #4;
    n_checks++;
    if (gnt !== 2'b10 || s_cyc !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_pre: gnt=%b s_cyc=%b required 10 1", gnt, s_cyc);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (gnt !== 2'b00 || s_cyc !== 1'b0 || m1_ack !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_async: gnt=%b s_cyc=%b m1_ack=%b required 00 0 0", gnt, s_cyc, m1_ack);
    end
    s_ack = 1'b0;
    step();
    rst = 1'b0;
    m0_cyc = 1'b1;
    step(); #4;
    n_checks++;
    if (gnt !== 2'b01) begin n_fail++; $display("FAIL rst_mid_tie: gnt=%b required 01", gnt); end
    {m0_cyc, m1_cyc, m1_stb} = '0;
  endtask

  // Reference model: owner is the granted master (-1 when idle), last is the previously served one.
  task automatic test_random();
    int owner = -1, cnt = 0;
    bit lst = 1'b1, to;
    logic [1:0] cyc, stb, e_ack, e_err, e_gnt;
    logic [AW-1:0] adr [2];
    logic e_cyc;
    logic [AW-1:0] e_adr;
    do_reset();
    cyc = '0;
    for (int n = 0; n < 400; n++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(3) == 0) cyc[i] = ~cyc[i];
        stb[i] = cyc[i] & 1'($urandom);
        adr[i] = $urandom;
      end
      {m0_cyc, m1_cyc} = {cyc[0], cyc[1]};
      {m0_stb, m1_stb} = {stb[0], stb[1]};
      m0_adr = adr[0]; m1_adr = adr[1];
      s_ack = ($urandom_range(2) == 0);
      s_err = ($urandom_range(9) == 0);
      s_rdat = $urandom;
      to = WD && owner >= 0 && cnt == TO;
      e_gnt = owner == 0 ? 2'b01 : owner == 1 ? 2'b10 : 2'b00;
      e_cyc = owner >= 0 && !to && cyc[owner];
      e_adr = owner >= 0 ? adr[owner] : '0;
      for (int i = 0; i < 2; i++) begin
        e_ack[i] = owner == i && s_ack;
        e_err[i] = owner == i && (s_err || to);
      end
      #4;
      n_checks++;
      if (gnt !== e_gnt || s_cyc !== e_cyc || s_adr !== e_adr || {m1_ack, m0_ack} !== e_ack || {m1_err, m0_err} !== e_err
          || m0_rdat !== (owner == 0 ? s_rdat : '0) || m1_rdat !== (owner == 1 ? s_rdat : '0)) begin
        n_fail++;
        $display("FAIL random%0d: gnt=%b cyc=%b adr=%h ack=%b err=%b required gnt=%b cyc=%b adr=%h ack=%b err=%b",
                 n, gnt, s_cyc, s_adr, {m1_ack, m0_ack}, {m1_err, m0_err}, e_gnt, e_cyc, e_adr, e_ack, e_err);
      end
      if (owner < 0) begin
        owner = (cyc == 2'b11) ? (lst ? 0 : 1) : cyc[0] ? 0 : cyc[1] ? 1 : -1;
        cnt = 0;
      end else if (!cyc[owner] || to) begin
        lst = (owner == 1);
        owner = -1;
        cnt = 0;
      end else if (s_ack || s_err) cnt = 0;
      else if (stb[owner]) cnt++;
    end
    {m0_cyc, m1_cyc, m0_stb, m1_stb, s_ack, s_err} = '0;
  endtask

  initial begin
    test_reset();
    test_tie();
    test_m1_write();
    test_block();
    test_back_to_back();
    test_watchdog();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Two-master round-robin arbiter for the classic (non-pipelined) Wishbone bus, placed between the bench/CPU masters and the single wb-axi bridge slave port in the intercon. It grants the bridge to one master at a time for the full duration of its `cyc` assertion and routes the slave's responses back to the granted master only. An optional watchdog terminates cycles the AXI side never completes.

## Interface
Parameters:
- `AW`, 32, address width.
- `DW`, 32, data width; `sel` width is `DW/8`.
- `TIMEOUT`, 255, watchdog limit in `wb_clk` cycles (1..65535). Used only with the watchdog compiled in.

Ports:
- `wb_clk`  in  1  clock.
- `sys_rst_i`  in  1  reset, asynchronous, active-high.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i`  in  1 each  master 0 cycle/strobe/write-enable.
- `m0_adr_i`  in  AW  master 0 address.
- `m0_dat_i`  in  DW  master 0 write data.
- `m0_sel_i`  in  DW/8  master 0 byte selects.
- `m0_dat_o`  out  DW  master 0 read data.
- `m0_ack_o`, `m0_err_o`  out  1 each  master 0 responses.
- `m1_*`  same set as `m0_*`  master 1.
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1 each  to bridge.
- `s_adr_o`  out  AW; `s_dat_o` out DW; `s_sel_o` out DW/8  to bridge.
- `s_dat_i`  in  DW; `s_ack_i`, `s_err_i` in 1 each  from bridge.
- `gnt_o`  out  2  one-hot grant (`00` = idle), registered.

## Operation
- FSM states: IDLE, GNT0, GNT1. Register `last` (1 bit) holds the most recently granted master.
- IDLE: if exactly one `mX_cyc_i` is high, go to GNTX. If both are high, grant the master != `last`. If none, stay.
- GNTX: stay while `mX_cyc_i` is high. When `mX_cyc_i` is low, go to IDLE and set `last = X`. The other master is never granted directly from GNTX; one IDLE cycle always separates grants.
- Master side of the slave mux: in GNTX, `s_cyc_o/s_stb_o/s_we_o/s_adr_o/s_dat_o/s_sel_o` equal master X inputs (combinational). In IDLE, all `s_*` outputs are 0.
- Response routing:
  - `mX_ack_o = s_ack_i & (state==GNTX)`; `mX_err_o` is the same with `s_err_i`.
  - `mX_dat_o = s_dat_i` when granted, else 0.
  - A response arriving in IDLE is dropped.
- Grant is never preempted mid-cycle. A master may issue multiple `stb` transfers within one `cyc` (block cycle).

## Timing
- Reset values: state IDLE, `last = 1` (master 0 wins the first tie), `gnt_o = 00`, all `s_*` outputs 0, all `m*_ack_o/err_o` 0, `m*_dat_o` 0, watchdog count 0.
- Grant latency: request seen in IDLE at edge N, so `gnt_o` and `s_cyc_o` are high in cycle N+1.
- Release: `mX_cyc_i` low in cycle N, so `gnt_o = 00` in N+1 and the next grant is visible at the earliest in N+2.
- `s_*` outputs follow the granted master's inputs with zero-cycle combinational delay. Ack/err are returned to the master in the same cycle they arrive.
- Asserting reset mid-cycle forces IDLE immediately (asynchronous) and drops `s_cyc_o` at once. The interrupted master receives no ack.

## Configuration
- `WB_ARB_WATCHDOG_EN` defined:
  - A 16-bit counter increments each cycle that the grant is held with `s_stb_o=1` and `s_ack_i=s_err_i=0`. It clears on ack, err, or leaving GNTX.
  - When the count reaches `TIMEOUT`, for one cycle: `mX_err_o=1`, `s_cyc_o=s_stb_o=0`, counter cleared, FSM to IDLE, `last=X`.
  - The master must then drop `cyc`. If `cyc` is still high in IDLE, it is re-arbitrated normally.
- `WB_ARB_WATCHDOG_EN` undefined: no counter; `mX_err_o` is a pure passthrough of `s_err_i`; cycles may stall indefinitely.

## Test plan
- Reset, then `m0_cyc_i=m1_cyc_i=1` asserted together -> `gnt_o=01` one cycle later. After m0 drops `cyc`: `gnt_o=00` for one cycle, then `10`.
- m1 alone writes `adr=0x1000`, `dat=0xDEADBEEF`, `sel=0xF` -> identical values on `s_*` the cycle after grant. `m1_ack_o` follows `s_ack_i`; `m0_ack_o` stays 0.
- m0 block cycle of 4 reads with m1 requesting throughout -> m1 is not granted until m0 drops `cyc`. m0 receives 4 acks with `s_dat_i` values 1, 2, 3, 4.
- Continuous requests from both masters over 6 cycles -> grants alternate 01, 10, 01, with one idle cycle between each.
- Watchdog (macro on, `TIMEOUT=8`), m0 strobes with no slave ack -> `m0_err_o` pulses exactly 8 cycles after `s_stb_o` rises, with `s_cyc_o=0` in the same cycle. Macro off -> no err; grant held indefinitely.
- `sys_rst_i` pulsed mid-cycle while granted to m1 -> `s_cyc_o=0` and `gnt_o=00` without waiting for a clock edge. After release, a simultaneous request grants m0 first.
